// File: rtl/gen_collector.sv
// Caller-side engine for a ready/valid generator: launches a run, buffers yielded tuples, reports done once drained.
// Optional `GEN_COLLECTOR_THROTTLE_EN adds an LFSR that randomly deasserts gen_ready to exercise generator back-pressure.
module gen_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    cmd_start,
    input  logic signed [WIDTH-1:0] cmd_arg0,
    input  logic signed [WIDTH-1:0] cmd_arg1,
    input  logic signed [WIDTH-1:0] cmd_arg2,
    output logic                    cmd_busy,
    output logic                    cmd_done,
    output logic signed [WIDTH-1:0] gen_arg0,
    output logic signed [WIDTH-1:0] gen_arg1,
    output logic signed [WIDTH-1:0] gen_arg2,
    output logic                    gen_start,
    output logic                    gen_ready,
    input  logic                    gen_valid,
    input  logic                    gen_done,
    input  logic signed [WIDTH-1:0] gen_out0,
    input  logic signed [WIDTH-1:0] gen_out1,
    input  logic                    rd_en,
    output logic                    rd_valid,
    output logic signed [WIDTH-1:0] rd_out0,
    output logic signed [WIDTH-1:0] rd_out1,
    output logic [CNT_W-1:0]        item_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              r_state;
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_occ;
    logic [WIDTH-1:0]        r_mem0 [DEPTH];
    logic [WIDTH-1:0]        r_mem1 [DEPTH];
    logic [CNT_W-1:0]        r_item_count;
    logic signed [WIDTH-1:0] r_arg0;
    logic signed [WIDTH-1:0] r_arg1;
    logic signed [WIDTH-1:0] r_arg2;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_launch;

`ifdef GEN_COLLECTOR_THROTTLE_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci taps 16,14,13,11
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge _clock) begin
        if (_reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_ready = (r_state == S_RUN) && (r_occ != OCC_FULL) && r_lfsr[0];
`else
    assign w_ready = (r_state == S_RUN) && (r_occ != OCC_FULL);
`endif

    assign w_push   = w_ready && gen_valid;
    assign w_pop    = rd_en && (r_occ != '0);
    assign w_launch = cmd_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge _clock) begin
        if (_reset) begin
            r_state      <= S_IDLE;
            r_item_count <= '0;
            r_arg0       <= '0;
            r_arg1       <= '0;
            r_arg2       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch) begin
                        r_arg0       <= cmd_arg0;
                        r_arg1       <= cmd_arg1;
                        r_arg2       <= cmd_arg2;
                        r_item_count <= '0;
                        r_state      <= S_START;
                    end
                end
                // gen_done is stale from the previous run while in START
                S_START: r_state <= S_RUN;
                S_RUN: begin
                    if (w_push && (r_item_count != '1)) begin
                        r_item_count <= r_item_count + CNT_W'(1);
                    end
                    if (gen_done) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_occ == '0) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge _clock) begin
        if (_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge _clock) begin
        if (w_push) begin
            r_mem0[r_wr_ptr] <= gen_out0;
            r_mem1[r_wr_ptr] <= gen_out1;
        end
    end

    assign rd_valid   = (r_occ != '0);
    assign rd_out0    = rd_valid ? r_mem0[r_rd_ptr] : '0;
    assign rd_out1    = rd_valid ? r_mem1[r_rd_ptr] : '0;
    assign cmd_busy   = (r_state == S_START) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign cmd_done   = (r_state == S_DONE);
    assign gen_start  = (r_state == S_START);
    assign gen_ready  = w_ready;
    assign gen_arg0   = r_arg0;
    assign gen_arg1   = r_arg1;
    assign gen_arg2   = r_arg2;
    assign item_count = r_item_count;

endmodule

// File: tb/tb_gen_collector.sv
// Bench for gen_collector: behavioural range generator, scoreboard on the read side, table of runs plus corner sequences.
module tb_gen_collector;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                cmd_start;
    logic signed [W-1:0] a0, a1, a2;
    logic                cmd_busy, cmd_done;
    logic signed [W-1:0] gen_arg0, gen_arg1, gen_arg2;
    logic                gen_start, gen_ready, gen_valid, gen_done;
    logic signed [W-1:0] gen_out0, gen_out1;
    logic                rd_en, rd_valid;
    logic signed [W-1:0] rd_out0, rd_out1;
    logic [CW-1:0]       item_count;

    gen_collector #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        ._clock(clk), ._reset(rst),
        .cmd_start(cmd_start), .cmd_arg0(a0), .cmd_arg1(a1), .cmd_arg2(a2),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done),
        .gen_arg0(gen_arg0), .gen_arg1(gen_arg1), .gen_arg2(gen_arg2),
        .gen_start(gen_start), .gen_ready(gen_ready),
        .gen_valid(gen_valid), .gen_done(gen_done),
        .gen_out0(gen_out0), .gen_out1(gen_out1),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_out0(rd_out0), .rd_out1(rd_out1),
        .item_count(item_count)
    );

    // Range generator model: yields cur while cur < stop; done is held high when idle
    logic signed [W-1:0] g_cur, g_stop, g_step;
    logic                g_inv;
    always @(posedge clk) begin
        if (rst) begin
            g_cur  <= '0;
            g_stop <= '0;
            g_step <= 1;
        end else if (gen_start) begin
            g_cur  <= gen_arg0;
            g_stop <= gen_arg1;
            g_step <= gen_arg2;
        end else if (gen_valid && gen_ready) begin
            g_cur <= g_cur + g_step;
        end
    end
    assign gen_done  = (g_cur >= g_stop);
    assign gen_valid = !gen_done;
    assign gen_out0  = g_cur;
    assign gen_out1  = g_inv ? ~g_cur : g_cur;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int n_xfer  = 0;
    int occ     = 0;
    int rdv_cnt = 0;

    // Monitor: decides at the falling edge what the next rising edge will transfer
    always @(negedge clk) begin
        if (rst) begin
            occ = 0;
            q0.delete();
            q1.delete();
        end else begin
            if (gen_valid && gen_ready) begin
                n_xfer++;
                occ++;
            end
            if (rd_valid) rdv_cnt++;
            if (rd_en && rd_valid) begin
                if (q0.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("rd_out0", rd_out0, q0.pop_front());
                    check("rd_out1", rd_out1, q1.pop_front());
                end
                occ--;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int s0, input int s1, input int s2);
        for (int v = s0; v < s1; v += s2) begin
            q0.push_back(W'(v));
            q1.push_back(g_inv ? ~W'(v) : W'(v));
        end
        a0 = s0; a1 = s1; a2 = s2;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        check("gen_start_pulse", gen_start, 1);
        check("busy_in_start", cmd_busy, 1);
        check("done_dropped", cmd_done, 0);
        check("gen_arg0_latched", gen_arg0, W'(s0));
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!cmd_done && k < bound) begin
            step();
            k++;
        end
        if (!cmd_done) check("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        int s0, s1, s2;
        bit inv;
        bit hold;
        int exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int bp_bad, low_seen, base, k;
        rst = 1'b1; cmd_start = 0; a0 = 0; a1 = 0; a2 = 0; rd_en = 0; g_inv = 0;

        vecs[0] = '{0, 10, 2, 1'b0, 1'b0, 5};
        vecs[1] = '{1, 11, 3, 1'b0, 1'b1, 4};
        vecs[2] = '{-6, 3, 3, 1'b1, 1'b0, 3};
        vecs[3] = '{7, 8, 1, 1'b1, 1'b1, 1};
        vecs[4] = '{0, 10, 2, 1'b0, 0, 5};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", cmd_busy, 0);
        check("rst_done", cmd_done, 0);
        check("rst_start", gen_start, 0);
        check("rst_ready", gen_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_out0", rd_out0, 0);
        check("rst_count", item_count, 0);
        check("rst_arg0", gen_arg0, 0);
        rst = 1'b0;
        step();

        // Table runs; consecutive entries restart from DONE
        for (int i = 0; i < 5; i++) begin
            g_inv = vecs[i].inv;
            rd_en = !vecs[i].hold;
            bp_bad = 0;
            low_seen = 0;
            issue(vecs[i].s0, vecs[i].s1, vecs[i].s2);
            step();
            k = 0;
            while (!gen_done && k < 500) begin
                if (!gen_ready && occ < D) bp_bad++;
                if (!gen_ready) low_seen++;
                step();
                k++;
            end
            if (vecs[i].hold) begin
                step();
                step();
                check("drain_held_busy", cmd_busy, 1);
                check("drain_held_done", cmd_done, 0);
                check("drain_occ", rd_valid, 1);
                rd_en = 1'b1;
            end
            wait_done(500);
            check("item_count", item_count, W'(vecs[i].exp_cnt));
            check("sb_empty", q0.size(), 0);
`ifdef GEN_COLLECTOR_THROTTLE_EN
            if (i == 0) check("throttle_low_seen", low_seen > 0, 1);
`else
            check("ready_when_space", bp_bad, 0);
`endif
            repeat (3) step();
            check("done_held", cmd_done, 1);
            check("idle_rd_valid", rd_valid, 0);
        end

        // FIFO full: generator must hold 16 while ready is low
        g_inv = 0;
        rd_en = 1'b0;
        base = n_xfer;
        issue(0, 40, 2);
        k = 0;
        while (n_xfer - base < 8 && k < 500) begin
            step();
            k++;
        end
        step();
        step();
        check("full_ready_low", gen_ready, 0);
        check("full_valid_held", gen_valid, 1);
        check("full_value", gen_out0, 16);
        check("full_count", item_count, 8);
        rd_en = 1'b1;
        wait_done(1000);
        check("full_final_count", item_count, 20);
        check("full_sb_empty", q0.size(), 0);

        // Empty run
        base = rdv_cnt;
        issue(5, 5, 1);
        k = 0;
        while (!cmd_done && k < 20) begin
            step();
            k++;
        end
        check("empty_done_latency_ok", k <= 4, 1);
        check("empty_done", cmd_done, 1);
        check("empty_count", item_count, 0);
        check("empty_no_rd_valid", rdv_cnt - base, 0);

        // Reset mid-run after two transfers
        rd_en = 1'b0;
        base = n_xfer;
        issue(0, 10, 2);
        k = 0;
        while (n_xfer - base < 2 && k < 500) begin
            step();
            k++;
        end
        check("mid_two_held", rd_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_busy", cmd_busy, 0);
        check("mid_rst_done", cmd_done, 0);
        check("mid_rst_count", item_count, 0);
        step();
        rd_en = 1'b1;
        issue(0, 10, 2);
        wait_done(500);
        check("after_rst_count", item_count, 5);
        check("after_rst_sb_empty", q0.size(), 0);

        // cmd_start during RUN is ignored
        issue(0, 10, 2);
        step();
        a0 = 100; a1 = 200; a2 = 1;
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        check("ignore_arg0", gen_arg0, 0);
        check("ignore_busy", cmd_busy, 1);
        check("ignore_no_start", gen_start, 0);
        wait_done(500);
        check("ignore_count", item_count, 5);
        check("ignore_sb_empty", q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
